// File: rtl/mem_data_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory.
// One winner is latched, drives memory for one cycle, then completes.
module mem_data_arbiter #(
  parameter int XLEN       = 32,
  parameter int TAM        = 16,
  parameter int ADDRESSLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDRESSLEN-1:0] addr0,
  input  logic [ADDRESSLEN-1:0] addr1,
  input  logic [XLEN-1:0]       wdata0,
  input  logic [XLEN-1:0]       wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  err0,
  output logic                  err1,
  output logic [XLEN-1:0]       rdata0,
  output logic [XLEN-1:0]       rdata1,
  output logic [ADDRESSLEN-1:0] mem_writeAddress,
  output logic [ADDRESSLEN-1:0] mem_readAddress,
  output logic [XLEN-1:0]       mem_data,
  output logic                  mem_writeEnabled,
  output logic                  mem_readEnabled,
  input  logic [XLEN-1:0]       mem_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state;
  state_t                nxt;
  logic                  owner;
  logic                  last;
  logic                  lat_we;
  logic [ADDRESSLEN-1:0] lat_addr;
  logic [XLEN-1:0]       lat_wdata;
  logic                  any_req;
  logic                  win;
  logic                  accept;
  logic                  lat_err;

  assign any_req = req0 | req1;
  // On conflict the port not served last wins
  assign win     = (req0 & req1) ? ~last : req1;
  assign accept  = any_req & ((state == IDLE) | (state == DONE));
  assign lat_err = (lat_addr[1:0] != 2'b00) ||
    (lat_addr[ADDRESSLEN-1:2] >= (ADDRESSLEN-2)'(TAM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE:    nxt = any_req ? ACCESS : IDLE;
      ACCESS:  nxt = DONE;
      DONE:    nxt = any_req ? ACCESS : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0             = 1'b0;
    gnt1             = 1'b0;
    done0            = 1'b0;
    done1            = 1'b0;
    err0             = 1'b0;
    err1             = 1'b0;
    mem_writeEnabled = 1'b0;
    mem_readEnabled  = 1'b0;
    unique case (1'b1)
      (state == ACCESS): begin
        gnt0             = ~owner;
        gnt1             = owner;
        mem_writeEnabled = lat_we & ~lat_err;
        mem_readEnabled  = ~lat_we & ~lat_err;
      end
      (state == DONE): begin
        done0 = ~owner;
        done1 = owner;
        err0  = ~owner & lat_err;
        err1  = owner & lat_err;
      end
      default: ;
    endcase
  end

  assign mem_writeAddress = lat_addr;
  assign mem_readAddress  = lat_addr;
  assign mem_data         = lat_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      owner     <= win;
      last      <= win;
      lat_we    <= win ? we1 : we0;
      lat_addr  <= win ? addr1 : addr0;
      lat_wdata <= win ? wdata1 : wdata0;
    end
  end

  // Read word is captured at the edge that ends ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS) begin
      if (!owner) begin
        if (lat_err)     rdata0 <= '0;
        else if (!lat_we) rdata0 <= mem_out;
      end else begin
        if (lat_err)     rdata1 <= '0;
        else if (!lat_we) rdata1 <= mem_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a behavioural
// data memory (posedge write, negedge registered read).
module tb_mem_data_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_writeAddress, mem_readAddress, mem_data;
  logic        mem_writeEnabled, mem_readEnabled;
  logic [31:0] mem_out;
  logic [31:0] mem [16];

  int checks;
  int failures;

  mem_data_arbiter #(
    .XLEN(32), .TAM(16), .ADDRESSLEN(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_writeAddress(mem_writeAddress),
    .mem_readAddress(mem_readAddress),
    .mem_data(mem_data),
    .mem_writeEnabled(mem_writeEnabled),
    .mem_readEnabled(mem_readEnabled),
    .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_writeEnabled) mem[mem_writeAddress[5:2]] = mem_data;

  always @(negedge clk)
    if (mem_readEnabled) mem_out <= mem[mem_readAddress[5:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    #3;
    v = {gnt0, gnt1, done0, done1, err0, err1,
         mem_writeEnabled, mem_readEnabled};
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags got %h exp 00", v);
    end
    checks++;
    if ({rdata0, rdata1, mem_writeAddress} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got %h %h %h exp 0",
               rdata0, rdata1, mem_writeAddress);
    end
    tick();
    rst_n = 1'b1;
    req0 = 1; req1 = 1; addr0 = 32'h0; addr1 = 32'h4;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_gnt got %b exp 10", {gnt0, gnt1});
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 32'h8; wdata0 = 32'hDEADBEEF;
    tick();
    checks++;
    if ({gnt0, mem_writeEnabled, mem_readEnabled} !== 3'b110) begin
      failures++;
      $display("FAIL wr_gnt got %b exp 110",
               {gnt0, mem_writeEnabled, mem_readEnabled});
    end
    req0 = 0;
    tick();
    checks++;
    if ({done0, err0, gnt0, mem_writeEnabled} !== 4'b1000) begin
      failures++;
      $display("FAIL wr_done got %b exp 1000",
               {done0, err0, gnt0, mem_writeEnabled});
    end
    checks++;
    if (mem[2] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_mem got %h exp deadbeef", mem[2]);
    end
    req0 = 1; we0 = 0;
    tick();
    checks++;
    if ({gnt0, mem_writeEnabled, mem_readEnabled} !== 3'b101) begin
      failures++;
      $display("FAIL rd_gnt got %b exp 101",
               {gnt0, mem_writeEnabled, mem_readEnabled});
    end
    req0 = 0;
    tick();
    checks++;
    if ({done0, err0} !== 2'b10 || rdata0 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_done got %b %h exp 10 deadbeef",
               {done0, err0}, rdata0);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic [3:0] exp_v;
    logic [3:0] v;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    addr0 = 32'h0; addr1 = 32'h4;
    for (int i = 0; i < 8; i++) begin
      tick();
      case (i % 4)
        0: exp_v = 4'b1000;
        1: exp_v = 4'b0010;
        2: exp_v = 4'b0100;
        default: exp_v = 4'b0001;
      endcase
      v = {gnt0, gnt1, done0, done1};
      checks++;
      if (v !== exp_v) begin
        failures++;
        $display("FAIL conflict_seq%0d got %b exp %b", i, v, exp_v);
      end
      if (i == 1 || i == 5) begin
        checks++;
        if (rdata0 !== 32'h11) begin
          failures++;
          $display("FAIL conflict_rd0 got %h exp 11", rdata0);
        end
      end
      if (i == 3 || i == 7) begin
        checks++;
        if (rdata1 !== 32'h22) begin
          failures++;
          $display("FAIL conflict_rd1 got %h exp 22", rdata1);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_errors();
    req1 = 1; we1 = 0; addr1 = 32'h6;
    tick();
    checks++;
    if ({gnt1, mem_writeEnabled, mem_readEnabled} !== 3'b100) begin
      failures++;
      $display("FAIL mis_gnt got %b exp 100",
               {gnt1, mem_writeEnabled, mem_readEnabled});
    end
    req1 = 0;
    tick();
    checks++;
    if ({done1, err1} !== 2'b11 || rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL mis_done got %b %h exp 11 0", {done1, err1}, rdata1);
    end
    req0 = 1; we0 = 0; addr0 = 32'h40;
    tick();
    checks++;
    if ({gnt0, mem_writeEnabled, mem_readEnabled} !== 3'b100) begin
      failures++;
      $display("FAIL oor_gnt got %b exp 100",
               {gnt0, mem_writeEnabled, mem_readEnabled});
    end
    req0 = 0;
    tick();
    checks++;
    if ({done0, err0} !== 2'b11 || rdata0 !== 32'h0) begin
      failures++;
      $display("FAIL oor_done got %b %h exp 11 0", {done0, err0}, rdata0);
    end
    tick();
    checks++;
    if ({done0, err0, done1, err1} !== 4'b0000) begin
      failures++;
      $display("FAIL err_clear got %b exp 0000",
               {done0, err0, done1, err1});
    end
  endtask

  task automatic test_back_to_back();
    req1 = 1; we1 = 1; addr1 = 32'h4; wdata1 = 32'hAAAA0001;
    tick();
    checks++;
    if ({gnt1, mem_writeEnabled} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_gnt_a got %b exp 11", {gnt1, mem_writeEnabled});
    end
    addr1 = 32'hC; wdata1 = 32'hBBBB0002;
    tick();
    checks++;
    if ({gnt1, done1, err1} !== 3'b010) begin
      failures++;
      $display("FAIL b2b_done_a got %b exp 010", {gnt1, done1, err1});
    end
    tick();
    checks++;
    if ({gnt1, done1, mem_writeEnabled} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_gnt_b got %b exp 101",
               {gnt1, done1, mem_writeEnabled});
    end
    req1 = 0;
    tick();
    checks++;
    if (done1 !== 1'b1 || mem[1] !== 32'hAAAA0001 ||
        mem[3] !== 32'hBBBB0002) begin
      failures++;
      $display("FAIL b2b_mem got %b %h %h exp 1 aaaa0001 bbbb0002",
               done1, mem[1], mem[3]);
    end
    tick();
  endtask

  task automatic test_reset_access();
    req0 = 1; we0 = 1; addr0 = 32'h0; wdata0 = 32'h55;
    tick();
    checks++;
    if (gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL rst_acc_gnt got %b exp 1", gnt0);
    end
    req0 = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, mem_writeEnabled} !== 2'b00) begin
      failures++;
      $display("FAIL rst_acc_drop got %b exp 00", {gnt0, mem_writeEnabled});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (done0 !== 1'b0 || mem[0] !== 32'h11) begin
      failures++;
      $display("FAIL rst_acc_mem got %b %h exp 0 11", done0, mem[0]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem_out = 32'h0;
    rst_n = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_write_read();
    test_conflict();
    test_errors();
    test_back_to_back();
    test_reset_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_data_arbiter.md
# mem_data_arbiter

Two-port round-robin arbiter that shares the single-port data memory (write on posedge, read registered on negedge) between two requesters, e.g. core load/store unit (port 0) and debug/loader port (port 1). The block latches one winning request at a time, drives the memory for exactly one cycle, captures the read word, and returns it with a completion pulse and an error flag. It sits directly between the requesters and the data memory instance.

## Interface
- XLEN, 32, data word width
- TAM, 16, memory depth in words; must match the memory instance
- ADDRESSLEN, 32, byte-address width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, port 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDRESSLEN  byte address
- wdata0 / wdata1  in  XLEN  write data
- gnt0 / gnt1  out  1  request accepted; high for the ACCESS cycle
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with done: misaligned or out-of-range access
- rdata0 / rdata1  out  XLEN  read data; valid with done, held until next done on that port
- mem_writeAddress, mem_readAddress  out  ADDRESSLEN  to memory
- mem_data  out  XLEN  memory write data
- mem_writeEnabled, mem_readEnabled  out  1  memory enables
- mem_out  in  XLEN  memory read data (registered by memory on negedge)

## Operation
- Registered state: state, owner id, latched addr/we/wdata, last-served pointer, rdata0/1, done/err/gnt.
- FSM: IDLE, ACCESS, DONE.
  - IDLE: if any req at posedge -> latch winner, go ACCESS; else stay.
  - ACCESS: memory driven from latched regs; gnt_owner=1. At posedge ending ACCESS, capture mem_out (reads) into rdata_owner, go DONE.
  - DONE: done_owner=1, err_owner valid. Requests sampled here exactly as in IDLE: any req -> latch winner, go ACCESS; else IDLE.
- Arbitration: only one req -> that port. Both -> port != last-served. Last-served updates at each acceptance.
- Requester rule: hold req/we/addr/wdata stable until gnt; req still high when sampled in DONE counts as a new request.
- Error: addr[1:0] != 0 or addr[ADDRESSLEN-1:2] >= TAM -> error. Enables stay 0 in ACCESS, rdata_owner := 0, err_owner=1 in DONE. Otherwise err=0.
- Memory outputs: mem_writeAddress = mem_readAddress = latched addr in all states; mem_data = latched wdata; mem_writeEnabled = (ACCESS & we & !error); mem_readEnabled = (ACCESS & !we & !error). Outside ACCESS both enables 0.
- Write completion: done pulses, rdata unchanged, err 0.

## Timing
- Reset (async, rst_n=0): state=IDLE, last-served=1 (port 0 wins first conflict), latched addr/wdata=0, we=0, all gnt/done/err=0, rdata0=rdata1=0, mem enables 0.
- Latency: req sampled at edge E -> gnt high cycle E..E+1 -> done high cycle E+1..E+2. Read data valid with done.
- Throughput: continuous requests -> one access per 2 cycles (ACCESS, DONE alternating); both ports continuously -> strictly alternating.
- gnt and done never high simultaneously on the same port; at most one gnt and one done high in any cycle (done of one port may coincide with nothing else; next gnt follows next cycle).
- Reset mid-ACCESS: transaction dropped, no done, memory write not performed if rst_n low at ending edge.
- Unselected port's req ignored (no state change) until its turn.

## Test plan
- Reset: rst_n=0 mid-sim -> all outputs 0, state IDLE; first conflicting req0/req1 after release -> gnt0 first.
- Single write then read, port 0: write addr 0x8 data 0xDEADBEEF, then read addr 0x8 -> done0 two cycles after each accept, rdata0=0xDEADBEEF, err0=0, mem_writeEnabled high exactly one cycle.
- Conflict: req0 and req1 both held high reading 0x0 and 0x4 (preloaded 0x11, 0x22) -> gnt order 0,1,0,1; rdata0=0x11, rdata1=0x22 each 2 cycles apart.
- Errors: read addr 0x6 (misaligned) and 0x40 with TAM=16 (out of range) -> done+err, rdata=0, both mem enables 0 throughout.
- Back-to-back same port: req1 held across DONE writing 0x4 then 0xC -> second gnt1 in cycle right after done1, both words stored.
- Reset during ACCESS of write 0x0 <- 0x55 -> no done, memory word 0x0 unchanged.
